imem_dp: RTL
============

Name: imem_dp

Overview:
Parametrised dual-port instruction memory, successor to the single-port on-chip imem.
- Avalon-MM slave port (s1): program load and debug read/write with byte enables.
- Independent instruction-fetch port: req/ready handshake, configurable read latency, pipeline stall and fetch error reporting.
- Optional power-on scrub state machine that zeroes the array before the core may fetch.
- Sits between the RISC-V fetch stage and the system interconnect.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_W, 10, s1 word-address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LATENCY, 1, fetch latency in cycles from accept to fetch_valid; legal values 1 or 2.
- ZERO_INIT, 1, 1 = scrub the array to zero after reset; 0 = skip the scrub.
- NOP_WORD, 32'h00000013, value driven on fetch_instr when fetch_err is set.

Ports:
- clk_clk  in  1  single clock for the whole block.
- reset_reset_n  in  1  reset; synchronous, active-low.
- s1_address  in  ADDR_W  word address.
- s1_chipselect  in  1  selects the s1 port.
- s1_clken  in  1  s1 clock enable; when 0, s1 ignores all inputs and holds readdata.
- s1_write  in  1  1 = write, 0 = read.
- s1_writedata  in  DATA_W  write data.
- s1_byteenable  in  DATA_W/8  per-byte write enables.
- s1_readdata  out  DATA_W  registered read data.
- s1_waitrequest  out  1  high while the scrub is in progress.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W+2  byte address of the fetch.
- fetch_stall  in  1  freezes the fetch pipeline.
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready.
- fetch_valid  out  1  fetch_instr and fetch_err are valid.
- fetch_instr  out  DATA_W  fetched instruction word.
- fetch_err  out  1  the fetch was misaligned or out of range.

Behaviour:
- Reset: reset_reset_n sampled low on a rising edge clears all outputs: s1_readdata=0, fetch_valid=0, fetch_instr=0, fetch_err=0, fetch_ready=0. The FSM goes to CLEAR (ZERO_INIT=1) or RUN (ZERO_INIT=0). Memory contents are not reset except by the scrub.
- FSM CLEAR:
  - Counter starts at 0 and writes zero to word[cnt], one word per cycle.
  - After word DEPTH-1 is written, the FSM moves to RUN the next cycle; the scrub takes DEPTH cycles.
  - During CLEAR: s1_waitrequest=1, fetch_ready=0, s1 accesses ignored.
  - Reset asserted during CLEAR restarts the counter at 0.
- FSM RUN: s1_waitrequest=0; stays in RUN until reset.
- s1 access:
  - Active only when chipselect && clken && RUN.
  - Write: updates the bytes selected by byteenable; other bytes are unchanged.
  - Read: s1_readdata updates 1 cycle later. It holds its value on idle cycles and on write cycles.
  - s1_address >= DEPTH: writes are dropped; reads return 0.
- fetch_ready = RUN && !fetch_stall.
- On accept: word index = fetch_addr[ADDR_W+1:2].
  - err = (fetch_addr[1:0] != 0) || (index >= DEPTH).
  - fetch_valid rises READ_LATENCY cycles after the accept.
  - If err: fetch_instr = NOP_WORD and fetch_err = 1. Otherwise: fetch_instr = array word and fetch_err = 0.
- Back-to-back accepts give one result per cycle (fully pipelined).
- A cycle with no accept produces a bubble: fetch_valid=0 READ_LATENCY cycles later. fetch_instr holds its last value.
- fetch_stall=1 freezes every pipeline stage, including the array read register: fetch_valid, fetch_instr and fetch_err hold. No new accept occurs. Nothing is lost or duplicated across a stall.
- Collision: an s1 write and a fetch accept to the same word in the same cycle return the OLD data to the fetch (read-before-write). The next fetch of that word returns the new data.
- s1 read and fetch of the same word in the same cycle both return the stored data.
- Reset during in-flight fetches: all pipeline valids are cleared; no result is delivered for those fetches.

Test Plan:
- Scrub: ZERO_INIT=1, DEPTH=16 → after reset release, waitrequest stays high exactly 16 cycles, then fetch_ready=1. Fetching 0x00..0x3C returns all zeros.
- Byte-enable load: s1 write addr 3 data 0xDEADBEEF be 4'b1111, then addr 3 data 0x00001234 be 4'b0011 → s1 read addr 3 returns 0xDEAD1234 one cycle after the read request.
- Pipelined fetch: READ_LATENCY=2; words 0..3 loaded with 0x10..0x13; fetch_req held for 4 cycles at 0x0,0x4,0x8,0xC → fetch_valid high on cycles 2..5, instr 0x10,0x11,0x12,0x13 in order.
- Errors: fetch 0x6 → fetch_err=1, instr 0x00000013. Fetch byte addr 4*DEPTH → fetch_err=1.
- Stall: assert fetch_stall for 3 cycles while 2 fetches are in flight → outputs frozen and fetch_ready=0 during the stall. After release, both results appear once, in order.
- Collision and reset: s1 write 0xAAAA5555 to word 5 in the same cycle as a fetch of 0x14 (old data 0x11111111) → fetch returns 0x11111111 and the next fetch returns 0xAAAA5555. Reset pulse with a fetch in flight → no fetch_valid afterwards.

Source files
------------

// File: rtl/imem_dp.sv
`timescale 1ns/1ps
// imem_dp: dual-port instruction memory.
//   s1 (Avalon-MM slave): program load / debug access with byte enables,
//     registered read data, waitrequest high while the power-on scrub runs.
//   fetch port: req/ready handshake, READ_LATENCY (1 or 2) cycle pipeline,
//     global stall, NOP substitution plus fetch_err on misaligned or
//     out-of-range fetches.
// Ports:
//   clk_clk, reset_reset_n (synchronous, active-low)
//   s1_address, s1_chipselect, s1_clken, s1_write, s1_writedata,
//   s1_byteenable, s1_readdata, s1_waitrequest
//   fetch_req, fetch_addr (byte address), fetch_stall, fetch_ready,
//   fetch_valid, fetch_instr, fetch_err
module imem_dp #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       DEPTH        = 1024,
  parameter int unsigned       ADDR_W       = 10,
  parameter int unsigned       READ_LATENCY = 1,
  parameter int unsigned       ZERO_INIT    = 1,
  parameter logic [DATA_W-1:0] NOP_WORD     = DATA_W'(32'h0000_0013)
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_clken,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_waitrequest,
  input  logic                  fetch_req,
  input  logic [ADDR_W+1:0]     fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_W-1:0]     fetch_instr,
  output logic                  fetch_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   scrub_cnt;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               run_c;
  logic               s1_act_c;
  logic               s1_in_range_c;
  logic [DATA_W-1:0]  s1_word_c;
  logic               accept_c;
  logic [ADDR_W-1:0]  fetch_idx_c;
  logic               fetch_in_range_c;
  logic               fetch_err_c;
  logic [DATA_W-1:0]  fetch_word_c;

  logic               pipe_v;
  logic               pipe_err;
  logic [DATA_W-1:0]  pipe_word;

  // State register and scrub counter
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= (ZERO_INIT != 0) ? CLEAR : RUN;
      scrub_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) scrub_cnt <= scrub_cnt + IDX_W'(1);
    end
  end

  // Next state: leave CLEAR once the last word has been zeroed
  always_comb begin
    state_d = state_q;
    run_c   = 1'b0;
    case (state_q)
      CLEAR: if (scrub_cnt == IDX_W'(DEPTH - 1)) state_d = RUN;
      RUN:   run_c = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign s1_waitrequest = ~run_c;

  // Address decode; comparisons done at 32 bits so DEPTH == 2**ADDR_W works
  assign s1_act_c         = s1_chipselect && s1_clken && run_c;
  assign s1_in_range_c    = 32'(s1_address) < DEPTH;
  assign s1_word_c        = mem[IDX_W'(s1_address)];

  assign fetch_ready      = run_c && !fetch_stall && reset_reset_n;
  assign accept_c         = fetch_req && fetch_ready;
  assign fetch_idx_c      = fetch_addr[ADDR_W+1:2];
  assign fetch_in_range_c = 32'(fetch_idx_c) < DEPTH;
  assign fetch_err_c      = (fetch_addr[1:0] != 2'b00) || !fetch_in_range_c;
  assign fetch_word_c     = fetch_in_range_c ? mem[IDX_W'(fetch_idx_c)] : '0;

  // Array write port: scrub has priority, then s1 byte writes
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n) begin
      if (!run_c) begin
        mem[scrub_cnt] <= '0;
      end else if (s1_act_c && s1_write && s1_in_range_c) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (s1_byteenable[b]) mem[IDX_W'(s1_address)][8*b +: 8] <= s1_writedata[8*b +: 8];
        end
      end
    end
  end

  // s1 read data register; holds on idle and write cycles
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1_readdata <= '0;
    end else if (s1_act_c && !s1_write) begin
      s1_readdata <= s1_in_range_c ? s1_word_c : '0;
    end
  end

  // Fetch pipeline; the array is sampled before the same-edge write lands,
  // which yields read-before-write on a collision. Stall freezes all stages.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pipe_v      <= 1'b0;
      pipe_err    <= 1'b0;
      pipe_word   <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_instr <= '0;
    end else if (!fetch_stall) begin
      pipe_v <= accept_c;
      if (accept_c) begin
        pipe_err  <= fetch_err_c;
        pipe_word <= fetch_word_c;
      end
      if (READ_LATENCY == 2) begin
        fetch_valid <= pipe_v;
        if (pipe_v) begin
          fetch_err   <= pipe_err;
          fetch_instr <= pipe_err ? NOP_WORD : pipe_word;
        end
      end else begin
        fetch_valid <= accept_c;
        if (accept_c) begin
          fetch_err   <= fetch_err_c;
          fetch_instr <= fetch_err_c ? NOP_WORD : fetch_word_c;
        end
      end
    end
  end

endmodule
